// File: rtl/instruction_fetch.sv
// instruction_fetch: sequential word fetch with stall hold, branch redirect and halt detection
module instruction_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC = 0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD = '1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  halted,
    output logic [15:0]           fetch_count
);
    typedef enum logic [1:0] {START, RUN, HALTED} state_t;
    localparam logic [ADDR_WIDTH-1:0] RST_ADDR = ADDR_WIDTH'(RESET_PC);
    state_t state;
    logic [ADDR_WIDTH-1:0] pc, rq_pc;
    logic accept;
    assign accept = state == RUN && !stall && !branch_taken;
    assign instr = imem_data;
    assign instr_pc = rq_pc;
    assign instr_valid = state == RUN;
    assign halted = state == HALTED;
    // a stalled cycle re-reads the presented word so the memory output stays put
    always_comb
        imem_address = state == HALTED ? rq_pc :
                       branch_taken    ? branch_target :
                       state == START  ? RST_ADDR :
                       stall           ? rq_pc : pc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= START;
            pc <= RST_ADDR;
            rq_pc <= RST_ADDR;
            fetch_count <= '0;
        end else if (state != HALTED) begin
            if (branch_taken) begin
                rq_pc <= branch_target;
                pc <= branch_target + 1'b1;
                state <= RUN;
            end else if (state == START) begin
                rq_pc <= RST_ADDR;
                pc <= RST_ADDR + 1'b1;
                state <= RUN;
            end else if (accept) begin
                rq_pc <= pc;
                pc <= pc + 1'b1;
                fetch_count <= fetch_count + {15'd0, fetch_count != 16'hFFFF};
                if (imem_data == HALT_WORD) state <= HALTED;
            end
        end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized scoreboard bench against a presented-address reference model
module tb_instruction_fetch;
    logic clk = 0, rst_n = 0;
    logic [9:0] imem_address, branch_target = 0, instr_pc;
    logic [31:0] imem_data = 0, instr;
    logic stall = 0, branch_taken = 0, instr_valid, halted;
    logic [15:0] fetch_count;
    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_address(imem_address), .imem_data(imem_data),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted),
        .fetch_count(fetch_count)
    );
    always #5 clk = ~clk;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    logic [31:0] mem [1024];
    always @(posedge clk) imem_data <= mem[imem_address];
    typedef struct {
        logic v;
        logic h;
        logic [9:0] pc;
        logic [31:0] ins;
        logic [15:0] cnt;
    } rec_t;
    rec_t q[$];
    int checks = 0, passes = 0;
    bit mon_en = 0;
    int mode = 0;
    logic [9:0] p = 0;
    int cnt = 0;
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask
    always @(negedge clk) begin : mon
        rec_t r;
        if (mon_en) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL scoreboard_empty: got no expectation, required one");
            end else begin
                r = q.pop_front();
                chk("instr_valid", 64'(instr_valid), 64'(r.v));
                chk("halted", 64'(halted), 64'(r.h));
                chk("fetch_count", 64'(fetch_count), 64'(r.cnt));
                if (r.v) begin
                    chk("instr_pc", 64'(instr_pc), 64'(r.pc));
                    chk("instr", 64'(instr), 64'(r.ins));
                end
            end
        end
    end
    // model tracks only the presented address, accept count and mode
    task automatic step(input logic s, input logic b, input logic [9:0] t);
        stall = s;
        branch_taken = b;
        branch_target = t;
        if (mode == 0) begin
            p = b ? t : 10'd0;
            mode = 1;
        end else if (mode == 1) begin
            if (b) p = t;
            else if (!s) begin
                if (cnt < 65535) cnt++;
                if (mem[p] == HALT) mode = 2;
                else p = p + 10'd1;
            end
        end
        q.push_back('{mode == 1, mode == 2, p, mem[p], 16'(cnt)});
        @(negedge clk);
        #1;
    endtask
    task automatic check_reset_vals(input string n);
        chk({n, "_addr"}, 64'(imem_address), 0);
        chk({n, "_valid"}, 64'(instr_valid), 0);
        chk({n, "_halted"}, 64'(halted), 0);
        chk({n, "_count"}, 64'(fetch_count), 0);
    endtask
    task automatic do_reset();
        mon_en = 0;
        rst_n = 0;
        stall = 0;
        branch_taken = 0;
        q.delete();
        @(negedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1;
        mode = 0;
        cnt = 0;
        p = 0;
        chk("start_valid", 64'(instr_valid), 0);
        mon_en = 1;
    endtask
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[7] = HALT;
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(1, 1, 10'd500);
        step(0, 0, 0);
        step(0, 1, 10'd1022);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 10'd3);
        do_reset();
        for (int i = 0; i < 12; i++) step(0, i % 4 == 3 ? 1'b0 : 1'b0, 0);
        step(0, 1, 10'd100);
        step(1, 1, 10'd200);
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        stall = 1;
        #2;
        mon_en = 0;
        rst_n = 0;
        #1;
        check_reset_vals("async");
        chk("async_instr_pc", 64'(instr_pc), 0);
        for (int e = 0; e < 8; e++) begin
            do_reset();
            for (int c = 0; c < 150; c++)
                step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 1) ? 10'($urandom_range(1015, 1023)) : 10'($urandom_range(0, 1023)));
        end
        @(negedge clk);
        mon_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
